// File: rtl/std_go_done_issue_if.sv
// Bundles the operand stream, result stream and go/done unit signals of std_go_done_issue.
// master: the issue block; slave: the environment (producer, consumer and attached unit).
interface std_go_done_issue_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  logic             unit_go;
  logic [WIDTH-1:0] unit_left;
  logic [WIDTH-1:0] unit_right;
  logic [WIDTH-1:0] unit_out;
  logic             unit_done;

  modport master (
    input  in_valid, in_left, in_right,
    output in_ready,
    output out_valid, out_data,
    input  out_ready,
    output unit_go, unit_left, unit_right,
    input  unit_out, unit_done
  );

  modport slave (
    output in_valid, in_left, in_right,
    input  in_ready,
    input  out_valid, out_data,
    output out_ready,
    input  unit_go, unit_left, unit_right,
    output unit_out, unit_done
  );
endinterface

// File: rtl/std_go_done_issue.sv
// Stream-to-go/done adapter: issues operand pairs to one go/done unit and buffers its result.
// Optional BUSY watchdog with sticky err is built when STD_GO_DONE_TIMEOUT_EN is defined.
module std_go_done_issue #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  std_go_done_issue_if.master  bus,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

  state_e           state_q, state_d;
  logic             go_q, go_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             accept;
  logic             timeout_hit;

  // The slot is only refilled from BUSY, so gating acceptance on an empty
  // (or draining) slot guarantees a captured result is never overwritten.
  assign bus.in_ready = (state_q == StIdle) && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef STD_GO_DONE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts completed BUSY cycles, so TIMEOUT-1 marks the TIMEOUT-th one.
  assign timeout_hit = (state_q == StBusy) && !bus.unit_done &&
                       (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (bus.unit_done || timeout_hit) begin
          state_d = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values; done outside BUSY is deliberately ignored.
  always_comb begin
    go_d    = go_q;
    left_d  = left_q;
    right_d = right_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;

    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          go_d    = 1'b1;
          left_d  = bus.in_left;
          right_d = bus.in_right;
        end
      end
      StBusy: begin
        if (bus.unit_done) begin
          go_d    = 1'b0;
          data_d  = bus.unit_out;
          valid_d = 1'b1;
        end else if (timeout_hit) begin
          go_d  = 1'b0;
          err_d = 1'b1;
        end
      end
      default: begin
        go_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      go_q    <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      go_q    <= go_d;
      left_q  <= left_d;
      right_q <= right_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.unit_go    = go_q;
  assign bus.unit_left  = left_q;
  assign bus.unit_right = right_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign busy           = (state_q != StIdle);
  assign err            = err_q;

endmodule

// File: tb/tb_std_go_done_issue.sv
// Directed bench for std_go_done_issue with a behavioural go/done unit (multiply or divide).
// Define STD_GO_DONE_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=4.
module tb_std_go_done_issue;

`ifdef STD_GO_DONE_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 128;
`endif

  logic clk;
  logic reset;
  logic busy;
  logic err;

  std_go_done_issue_if #(.WIDTH(8)) bus ();

  std_go_done_issue #(
    .WIDTH  (8),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unit: done pulses lat cycles after go is seen, restarts if go stays high.
  int   lat = 3;
  logic op_div = 1'b0;
  logic tie_done_low = 1'b0;
  int   m_cnt = 0;
  int   m_starts = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt         <= 0;
      bus.unit_done <= 1'b0;
      bus.unit_out  <= 8'd0;
    end else begin
      bus.unit_done <= 1'b0;
      if (bus.unit_go && !bus.unit_done) begin
        if (m_cnt == 0) m_starts <= m_starts + 1;
        if (m_cnt == lat - 1) begin
          bus.unit_done <= !tie_done_low;
          if (op_div) bus.unit_out <= (bus.unit_right == 8'd0) ? 8'hff
                                                               : bus.unit_left / bus.unit_right;
          else        bus.unit_out <= bus.unit_left * bus.unit_right;
          m_cnt <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else begin
        m_cnt <= 0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offers an operand pair and returns just after the edge that accepted it.
  task automatic issue(input logic [7:0] l, input logic [7:0] r);
    logic rdy;
    bit   ok;
    ok           = 1'b0;
    bus.in_left  = l;
    bus.in_right = r;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    bus.in_valid = 1'b0;
    check("issue_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_result(input string name, input logic [7:0] exp);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      if (bus.out_valid) begin
        ok = 1'b1;
        check(name, 32'(bus.out_data), 32'(exp));
      end
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic       div;
    int         lat;
    logic [7:0] l;
    logic [7:0] r;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] res[2];
  int         nacc, nres, gap_low, st0;
  logic       rdy;

  initial begin
    vecs[0] = '{1'b0, 3, 8'd7,   8'd6,   8'd42};
    vecs[1] = '{1'b0, 1, 8'd255, 8'd255, 8'd1};
    vecs[2] = '{1'b0, 2, 8'd16,  8'd16,  8'd0};
    vecs[3] = '{1'b1, 3, 8'd100, 8'd7,   8'd14};
    vecs[4] = '{1'b1, 1, 8'd200, 8'd9,   8'd22};
    vecs[5] = '{1'b1, 2, 8'd0,   8'd5,   8'd0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_left   = 8'd0;
    bus.in_right  = 8'd0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_go",        32'(bus.unit_go),    32'd0);
    check("rst_left",      32'(bus.unit_left),  32'd0);
    check("rst_right",     32'(bus.unit_right), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid),  32'd0);
    check("rst_out_data",  32'(bus.out_data),   32'd0);
    check("rst_busy",      32'(busy),           32'd0);
    check("rst_err",       32'(err),            32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready",  32'(bus.in_ready),   32'd1);

    // Cycle-exact multiply 7*6, unit latency 3.
    op_div = 1'b0;
    lat    = 3;
    issue(8'd7, 8'd6);
    check("mul_go_e0",    32'(bus.unit_go),    32'd1);
    check("mul_left_e0",  32'(bus.unit_left),  32'd7);
    check("mul_right_e0", 32'(bus.unit_right), 32'd6);
    check("mul_busy_e0",  32'(busy),           32'd1);
    check("mul_rdy_e0",   32'(bus.in_ready),   32'd0);
    tick();
    tick();
    tick();
    check("mul_done_e3",  32'(bus.unit_done),  32'd1);
    check("mul_go_e3",    32'(bus.unit_go),    32'd1);
    check("mul_valid_e3", 32'(bus.out_valid),  32'd0);
    tick();
    check("mul_valid_e4", 32'(bus.out_valid),  32'd1);
    check("mul_data_e4",  32'(bus.out_data),   32'd42);
    check("mul_go_e4",    32'(bus.unit_go),    32'd0);
    check("mul_busy_e4",  32'(busy),           32'd1);
    tick();
    check("mul_valid_e5", 32'(bus.out_valid),  32'd0);
    check("mul_rdy_e5",   32'(bus.in_ready),   32'd1);
    check("mul_busy_e5",  32'(busy),           32'd0);
    check("mul_hold_e5",  32'(bus.out_data),   32'd42);

    // Table of operand pairs across both unit kinds and latencies.
    foreach (vecs[k]) begin
      op_div = vecs[k].div;
      lat    = vecs[k].lat;
      issue(vecs[k].l, vecs[k].r);
      wait_result($sformatf("vec%0d", k), vecs[k].exp);
    end

    // Back-to-back divides with in_valid held high.
    op_div       = 1'b1;
    lat          = 3;
    tick();
    tick();
    st0          = m_starts;
    nacc         = 0;
    nres         = 0;
    gap_low      = 0;
    bus.in_left  = 8'd100;
    bus.in_right = 8'd7;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 60 && nres < 2; i++) begin
      @(negedge clk);
      rdy = bus.in_ready && bus.in_valid;
      if (nacc == 1 && !bus.unit_go) gap_low++;
      tick();
      if (rdy) begin
        nacc++;
        if (nacc == 1) begin
          bus.in_left  = 8'd200;
          bus.in_right = 8'd9;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        res[nres] = bus.out_data;
        nres++;
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_count", 32'(nres), 32'd2);
    check("b2b_res0",  32'(res[0]), 32'd14);
    check("b2b_res1",  32'(res[1]), 32'd22);
    check("b2b_gap",   32'(gap_low >= 1), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("b2b_starts", 32'(m_starts - st0), 32'd2);

    // Result held under backpressure while a second pair waits.
    op_div        = 1'b0;
    lat           = 3;
    bus.out_ready = 1'b0;
    issue(8'd7, 8'd6);
    wait_result("bp_first", 8'd42);
    bus.in_left  = 8'd5;
    bus.in_right = 8'd5;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      check("bp_data_hold",  32'(bus.out_data),  32'd42);
      check("bp_rdy_low",    32'(bus.in_ready),  32'd0);
      check("bp_go_low",     32'(bus.unit_go),   32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_rdy_same_cycle", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_go_second",   32'(bus.unit_go),   32'd1);
    check("bp_left_second", 32'(bus.unit_left), 32'd5);
    check("bp_valid_clr",   32'(bus.out_valid), 32'd0);
    wait_result("bp_second", 8'd25);

    // Reset two cycles into a divide discards it.
    op_div = 1'b1;
    lat    = 3;
    tick();
    tick();
    issue(8'd100, 8'd7);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_go",    32'(bus.unit_go),   32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),          32'd0);
    check("mid_rst_data",  32'(bus.out_data),  32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("mid_rst_no_result", 32'(bus.out_valid), 32'd0);
    issue(8'd9, 8'd3);
    wait_result("after_rst", 8'd3);

`ifdef STD_GO_DONE_TIMEOUT_EN
    // done on the fourth BUSY cycle wins over the watchdog.
    op_div = 1'b0;
    lat    = 3;
    tick();
    tick();
    issue(8'd7, 8'd6);
    wait_result("tie_capture", 8'd42);
    check("tie_err", 32'(err), 32'd0);

    // No done: abort after four BUSY cycles, err sticky until reset.
    tie_done_low = 1'b1;
    tick();
    tick();
    issue(8'd3, 8'd3);
    tick();
    tick();
    tick();
    check("to_go_e3",    32'(bus.unit_go),   32'd1);
    check("to_err_e3",   32'(err),           32'd0);
    tick();
    check("to_go_e4",    32'(bus.unit_go),   32'd0);
    check("to_err_e4",   32'(err),           32'd1);
    check("to_valid_e4", 32'(bus.out_valid), 32'd0);
    check("to_busy_e4",  32'(busy),          32'd1);
    tick();
    check("to_busy_e5",  32'(busy),          32'd0);
    check("to_rdy_e5",   32'(bus.in_ready),  32'd1);
    tick();
    tick();
    check("to_err_sticky", 32'(err),         32'd1);
    check("to_valid_late", 32'(bus.out_valid), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("to_err_cleared", 32'(err), 32'd0);
    tie_done_low = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/std_go_done_issue.md
Name: std_go_done_issue

Overview:
- Initiator side of the go/done protocol used by the pipelined arithmetic primitives (std_mult_pipe, std_div_pipe, std_mod_pipe, std_sdiv_pipe, std_smod_pipe).
- Accepts operand pairs on a valid/ready input stream and holds go plus stable operands to one attached unit until done.
- Captures the result into a one-entry valid/ready output slot, then drops go for one cycle so the unit re-arms.
- Lets stream-style datapaths reuse the existing go/done units unchanged.

Parameters:
- WIDTH, 32, operand and result width; must match the attached unit's width.
- TIMEOUT, 128, maximum BUSY cycles before abort; used only with the optional feature; must be at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  operand pair accepted when high with in_valid
- in_left  in  WIDTH  left operand
- in_right  in  WIDTH  right operand
- out_valid  out  1  result slot full
- out_ready  in  1  consumer takes the result
- out_data  out  WIDTH  result
- unit_go  out  1  go to the attached unit (registered)
- unit_left  out  WIDTH  left operand to the unit (registered)
- unit_right  out  WIDTH  right operand to the unit (registered)
- unit_out  in  WIDTH  unit result
- unit_done  in  1  unit done
- busy  out  1  high in BUSY or GAP
- err  out  1  sticky timeout flag

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, unit_go=0, unit_left=0, unit_right=0, out_valid=0, out_data=0, err=0, timeout counter=0.
- FSM states: IDLE, BUSY, GAP.
- Slot rule: in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational, with no path from in_valid. The slot is therefore always empty while BUSY, and a captured result is never dropped.
- IDLE transition: when in_valid && in_ready, latch in_left/in_right into unit_left/unit_right, set unit_go<=1, go to BUSY.
- BUSY: unit_go held at 1. unit_left/unit_right are held constant; std_mult_pipe resamples them every cycle.
- BUSY capture: on the first cycle unit_done==1, set out_data<=unit_out, out_valid<=1, unit_go<=0, go to GAP. Capture is edge-sampled; unit_out is not re-read afterwards.
- GAP: unit_go=0 for exactly one cycle. This clears the unit's done/running and prevents an unintended auto-restart, since go held high after done restarts std_div_pipe. Then go to IDLE.
- unit_done seen in IDLE or GAP is ignored.
- Output slot: out_valid clears on out_valid && out_ready. Capture and clear never coincide because the slot is empty in BUSY. out_data holds its value after the clear.
- Issue-to-issue minimum: unit latency + 2 cycles. The earliest unit_done is 1 cycle after unit_go rises.
- reset asserted in any state: after that edge, unit_go=0 and every output is at its reset value. The attached unit aborts because go is low. An in-flight result is discarded.
- busy = (state != IDLE).
- Arithmetic is pass-through; there is no width conversion.

Optional Feature:
- Macro: STD_GO_DONE_TIMEOUT_EN.
- Counting: with the macro, a counter clears on entry to BUSY and increments each BUSY cycle.
- Abort: if it reaches TIMEOUT with unit_done==0, set unit_go<=0, err<=1 (sticky until reset) and go to GAP. out_valid is not set.
- Tie-break: unit_done on the threshold cycle wins and produces a normal capture with no err.
- Without the macro: no counter is built, BUSY waits indefinitely, and err is constant 0.

Test Plan:
- WIDTH=8 with std_mult_pipe, in 7,6 accepted at edge 0, out_ready=1 -> unit_go high edges 0–3; unit_done high after edge 3; out_valid=1 and out_data=42 after edge 4; unit_go=0 after edge 4; in_ready=1 after edge 5.
- WIDTH=8 with std_div_pipe, back-to-back in 100,7 then 200,9, out_ready=1 -> outputs 14 then 22 in order. unit_go is low for exactly one cycle between the two operations; the divider never restarts spuriously.
- out_ready=0 after the result 42 -> out_valid and out_data=42 held, in_ready=0, a second operand stays pending. out_ready=1 for one cycle -> in_ready=1 that same cycle, and the second operand is accepted.
- reset pulsed 2 cycles after accept with std_div_pipe -> unit_go=0, out_valid=0, busy=0 after the reset edge. A new 9,3 afterwards yields 3.
- With STD_GO_DONE_TIMEOUT_EN, TIMEOUT=4, unit_done tied 0 -> after 4 BUSY cycles unit_go=0, err=1, out_valid stays 0, IDLE two cycles later, err persists until reset.
- With STD_GO_DONE_TIMEOUT_EN, TIMEOUT=4, unit_done asserted on BUSY cycle 4 -> normal capture, err=0.
